// File: rtl/scatter_queue.sv
// Buffered scatter unit: packed push groups enter a circular buffer, and the oldest
// words are scattered in order onto the requested output lanes through registered outputs.
module scatter_queue #(
    parameter int DATA  = 32,
    parameter int IN    = 8,
    parameter int OUT   = 8,
    parameter int DEPTH = 16,
    parameter bit ACT   = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic [IN-1:0][DATA-1:0]      i_in,
    input  logic [$clog2(IN+1)-1:0]      i_in_num,
    output logic                         o_in_ack,
    input  logic [OUT-1:0]               i_sel,
    output logic [OUT-1:0][DATA-1:0]     o_out,
    output logic [OUT-1:0]               o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic ENABLE  = ACT;
    localparam logic DISABLE = !ACT;

    logic [DATA-1:0]           r_mem [DEPTH];
    logic [PW-1:0]             r_rd;
    logic [PW-1:0]             r_wr;
    logic [CW-1:0]             r_count;
    logic [OUT-1:0][DATA-1:0]  r_out;
    logic [OUT-1:0]            r_valid;

    logic [OUT-1:0]            w_en;
    logic [CW-1:0]             w_space;
    logic [CW-1:0]             w_pushNum;
    logic [CW-1:0]             w_popCnt;
    logic [OUT-1:0][DATA-1:0]  w_popOut;
    logic [OUT-1:0]            w_popValid;

    assign w_en      = ACT ? i_sel : ~i_sel;
    assign w_space   = CW'(DEPTH) - r_count;
    assign o_in_ack  = (CW'(i_in_num) <= w_space) && !i_flush && !i_reset;
    assign w_pushNum = o_in_ack ? CW'(i_in_num) : '0;

    // Pop only sees words already resident, so a same-cycle push is never bypassed.
    always_comb begin
        w_popOut   = '0;
        w_popValid = {OUT{DISABLE}};
        w_popCnt   = '0;
        for (int i = 0; i < OUT; i++) begin
            if (w_en[i] && (w_popCnt < r_count)) begin
                w_popOut[i]   = r_mem[PW'(r_rd + w_popCnt[PW-1:0])];
                w_popValid[i] = ENABLE;
                w_popCnt      = w_popCnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < IN; k++) begin
            if (o_in_ack && (k < int'(i_in_num))) begin
                r_mem[PW'(r_wr + PW'(k))] <= i_in[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_out   <= '0;
            r_valid <= {OUT{DISABLE}};
        end else begin
            r_rd    <= r_rd + w_popCnt[PW-1:0];
            r_wr    <= r_wr + w_pushNum[PW-1:0];
            r_count <= r_count + w_pushNum - w_popCnt;
            r_out   <= w_popOut;
            r_valid <= w_popValid;
        end
    end

    assign o_out   = r_out;
    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: tb/tb_scatter_queue.sv
// Directed and model-based checks for scatter_queue, with one active-high and
// one active-low instance sharing the push-side inputs.
module tb_scatter_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             flush;
    logic [7:0][31:0] inData;
    logic [3:0]       inNum;
    logic [7:0]       selH, selL;

    logic             ackH, ackL;
    logic [7:0][31:0] outH, outL;
    logic [7:0]       validH, validL;
    logic [4:0]       countH, countL;
    logic             fullH, fullL, emptyH, emptyL;

    int total = 0;
    int bad   = 0;

    scatter_queue #(.DATA(32), .IN(8), .OUT(8), .DEPTH(16), .ACT(1'b1)) dutH (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_in(inData), .i_in_num(inNum),
        .o_in_ack(ackH), .i_sel(selH), .o_out(outH), .o_valid(validH),
        .o_count(countH), .o_full(fullH), .o_empty(emptyH)
    );

    scatter_queue #(.DATA(32), .IN(8), .OUT(8), .DEPTH(16), .ACT(1'b0)) dutL (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_in(inData), .i_in_num(inNum),
        .o_in_ack(ackL), .i_sel(selL), .o_out(outL), .o_valid(validL),
        .o_count(countL), .o_full(fullL), .o_empty(emptyL)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; inNum = 4'd3; inData = '0; selH = 8'hFF; selL = 8'h00;
        #1;
        total++; if (ackH !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack actual=%0b required=0", ackH); end
        tick;
        tick;
        total++; if (outH !== '0) begin bad++; $display("[TB] FAIL reset_out actual=%h required=0", outH); end
        total++; if (validH !== 8'h00) begin bad++; $display("[TB] FAIL reset_valid actual=%h required=00", validH); end
        total++; if (countH !== 5'd0) begin bad++; $display("[TB] FAIL reset_count actual=%0d required=0", countH); end
        total++; if (emptyH !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty actual=%0b required=1", emptyH); end
        total++; if (fullH !== 1'b0) begin bad++; $display("[TB] FAIL reset_full actual=%0b required=0", fullH); end
        total++; if (validL !== 8'hFF) begin bad++; $display("[TB] FAIL reset_valid_low actual=%h required=ff", validL); end
        rst = 1'b0; inNum = 4'd0; selH = 8'h00; selL = 8'hFF;
    endtask

    task automatic test_basic;
        logic [7:0][31:0] e;
        inNum = 4'd3; inData = '0; inData[0] = 32'd1; inData[1] = 32'd2; inData[2] = 32'd3;
        #1;
        total++; if (ackH !== 1'b1) begin bad++; $display("[TB] FAIL basic_ack actual=%0b required=1", ackH); end
        tick;
        inNum = 4'd0; selH = 8'b0010_0011;
        tick;
        e = '0; e[0] = 32'd1; e[1] = 32'd2; e[5] = 32'd3;
        total++; if (outH !== e) begin bad++; $display("[TB] FAIL basic_out actual=%h required=%h", outH, e); end
        total++; if (validH !== 8'h23) begin bad++; $display("[TB] FAIL basic_valid actual=%h required=23", validH); end
        total++; if (countH !== 5'd0) begin bad++; $display("[TB] FAIL basic_count actual=%0d required=0", countH); end
        selH = 8'h00;
    endtask

    task automatic test_partial;
        logic [7:0][31:0] e;
        inNum = 4'd2; inData = '0; inData[0] = 32'hA; inData[1] = 32'hB;
        tick;
        total++; if (countH !== 5'd2) begin bad++; $display("[TB] FAIL partial_fill actual=%0d required=2", countH); end
        inNum = 4'd0; selH = 8'hFF;
        tick;
        e = '0; e[0] = 32'hA; e[1] = 32'hB;
        total++; if (outH !== e) begin bad++; $display("[TB] FAIL partial_out actual=%h required=%h", outH, e); end
        total++; if (validH !== 8'h03) begin bad++; $display("[TB] FAIL partial_valid actual=%h required=03", validH); end
        total++; if (countH !== 5'd0) begin bad++; $display("[TB] FAIL partial_count actual=%0d required=0", countH); end
        total++; if (emptyH !== 1'b1) begin bad++; $display("[TB] FAIL partial_empty actual=%0b required=1", emptyH); end
        selH = 8'h00;
    endtask

    task automatic test_full;
        logic [7:0][31:0] e;
        inNum = 4'd8;
        for (int k = 0; k < 8; k++) inData[k] = 32'(100 + k);
        tick;
        for (int k = 0; k < 8; k++) inData[k] = 32'(200 + k);
        #1;
        total++; if (ackH !== 1'b1) begin bad++; $display("[TB] FAIL full_exactfit_ack actual=%0b required=1", ackH); end
        tick;
        total++; if (countH !== 5'd16) begin bad++; $display("[TB] FAIL full_count actual=%0d required=16", countH); end
        total++; if (fullH !== 1'b1) begin bad++; $display("[TB] FAIL full_flag actual=%0b required=1", fullH); end
        inNum = 4'd1; inData = '0; inData[0] = 32'd999; selH = 8'h01;
        #1;
        total++; if (ackH !== 1'b0) begin bad++; $display("[TB] FAIL full_ack actual=%0b required=0", ackH); end
        tick;
        e = '0; e[0] = 32'd100;
        total++; if (countH !== 5'd15) begin bad++; $display("[TB] FAIL full_pop_count actual=%0d required=15", countH); end
        total++; if (outH !== e) begin bad++; $display("[TB] FAIL full_pop_out actual=%h required=%h", outH, e); end
        total++; if (validH !== 8'h01) begin bad++; $display("[TB] FAIL full_pop_valid actual=%h required=01", validH); end
        inNum = 4'd0; selH = 8'h00;
    endtask

    task automatic test_wrap_low;
        logic [7:0][31:0] e;
        logic [7:0]       ev;
        logic             expAck;
        int nxt, exp, mCount, cyc, n, p;
        rst = 1'b1; tick; rst = 1'b0;
        nxt = 1; exp = 1; mCount = 0; cyc = 0;
        while ((nxt <= 40 || exp <= 40) && cyc < 200) begin
            n = (41 - nxt) < 3 ? (41 - nxt) : 3;
            inNum = 4'(n); inData = '0;
            for (int k = 0; k < 3; k++) inData[k] = 32'(nxt + k);
            selL = 8'hFC;
            #1;
            expAck = (n <= 16 - mCount);
            total++; if (ackL !== expAck) begin bad++; $display("[TB] FAIL wrap_ack cyc=%0d actual=%0b required=%0b", cyc, ackL, expAck); end
            p = mCount < 2 ? mCount : 2;
            e = '0; ev = 8'hFF;
            for (int k = 0; k < p; k++) begin e[k] = 32'(exp + k); ev[k] = 1'b0; end
            tick;
            if (expAck) begin nxt += n; mCount += n; end
            mCount -= p; exp += p;
            total++; if (validL !== ev) begin bad++; $display("[TB] FAIL wrap_valid cyc=%0d actual=%h required=%h", cyc, validL, ev); end
            total++; if (outL !== e) begin bad++; $display("[TB] FAIL wrap_out cyc=%0d actual=%h required=%h", cyc, outL, e); end
            total++; if (countL !== 5'(mCount)) begin bad++; $display("[TB] FAIL wrap_count cyc=%0d actual=%0d required=%0d", cyc, countL, mCount); end
            cyc++;
        end
        total++; if (exp != 41 || nxt != 41) begin bad++; $display("[TB] FAIL wrap_timeout popped_next=%0d required=41", exp); end
        inNum = 4'd0; selL = 8'hFF;
    endtask

    task automatic test_flush;
        rst = 1'b1; tick; rst = 1'b0;
        inNum = 4'd5;
        for (int k = 0; k < 8; k++) inData[k] = 32'(50 + k);
        tick;
        total++; if (countH !== 5'd5) begin bad++; $display("[TB] FAIL flush_fill actual=%0d required=5", countH); end
        flush = 1'b1; inNum = 4'd4; selH = 8'hFF;
        #1;
        total++; if (ackH !== 1'b0) begin bad++; $display("[TB] FAIL flush_ack actual=%0b required=0", ackH); end
        tick;
        flush = 1'b0; inNum = 4'd0; selH = 8'h00;
        total++; if (countH !== 5'd0) begin bad++; $display("[TB] FAIL flush_count actual=%0d required=0", countH); end
        total++; if (validH !== 8'h00) begin bad++; $display("[TB] FAIL flush_valid actual=%h required=00", validH); end
        total++; if (outH !== '0) begin bad++; $display("[TB] FAIL flush_out actual=%h required=0", outH); end
        total++; if (emptyH !== 1'b1) begin bad++; $display("[TB] FAIL flush_empty actual=%0b required=1", emptyH); end
    endtask

    task automatic test_random;
        logic [31:0]      q[$];
        logic [7:0][31:0] e;
        logic [7:0]       ev;
        logic             expAck;
        int p, sz;
        rst = 1'b1; tick; rst = 1'b0;
        q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            flush = ($urandom_range(0, 39) == 0);
            inNum = 4'($urandom_range(0, 8));
            for (int k = 0; k < 8; k++) inData[k] = $urandom;
            selH = 8'($urandom);
            #1;
            expAck = !flush && (int'(inNum) <= 16 - q.size());
            total++; if (ackH !== expAck) begin bad++; $display("[TB] FAIL rand_ack cyc=%0d actual=%0b required=%0b", cyc, ackH, expAck); end
            e = '0; ev = 8'h00;
            if (flush) begin
                q.delete();
            end else begin
                p = 0; sz = q.size();
                for (int i = 0; i < 8; i++) begin
                    if (selH[i] && p < sz) begin e[i] = q[p]; ev[i] = 1'b1; p++; end
                end
                for (int k = 0; k < p; k++) void'(q.pop_front());
                if (expAck) for (int k = 0; k < int'(inNum); k++) q.push_back(inData[k]);
            end
            tick;
            total++; if (outH !== e) begin bad++; $display("[TB] FAIL rand_out cyc=%0d actual=%h required=%h", cyc, outH, e); end
            total++; if (validH !== ev) begin bad++; $display("[TB] FAIL rand_valid cyc=%0d actual=%h required=%h", cyc, validH, ev); end
            total++; if (countH !== 5'(q.size())) begin bad++; $display("[TB] FAIL rand_count cyc=%0d actual=%0d required=%0d", cyc, countH, q.size()); end
        end
        flush = 1'b0; inNum = 4'd0; selH = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_full();
        test_wrap_low();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
